// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: single-transaction byte-serial RAM port shared between
// instruction fetch (IF) and load/store (LS) requesters.
// LS has fixed priority over IF. Defining STARVE_GUARD_EN adds a starvation
// guard: after 4 consecutive LS grants with IF waiting, the next grant goes to IF.
module ram_port_arbiter (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   input  logic        if_abort,
   output logic        if_done,
   output logic [31:0] if_data,
   input  logic        ls_req,
   input  logic        ls_we,
   input  logic [31:0] ls_addr,
   input  logic [31:0] ls_wdata,
   input  logic [2:0]  ls_len,
   input  logic        ls_signed,
   output logic        ls_done,
   output logic [31:0] ls_rdata,
   input  logic [7:0]  mem_din,
   input  logic        io_buffer_full,
   output logic [7:0]  mem_dout,
   output logic [31:0] mem_a,
   output logic        mem_wr,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

   state_t      state;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [2:0]  n;
   logic        sgn;
   logic        owner_ls;
   logic [2:0]  idx;
   logic [23:0] rbuf;

   logic        if_ok;
   logic        grant_if;
   logic        grant_ls;
   logic [2:0]  idx_next;
   logic [31:0] addr_next;
   logic [7:0]  wr_byte;
   logic [31:0] load_word;
   logic [2:0]  ls_n;

`ifdef STARVE_GUARD_EN
   logic [2:0]  starve;
`endif

   assign busy = (state != IDLE);

   // Grant decision for the IDLE state; an aborting fetch is never granted
   always_comb begin
      if_ok = if_req & ~if_abort;
`ifdef STARVE_GUARD_EN
      grant_if = if_ok & (~ls_req | (starve == 3'd4));
`else
      grant_if = if_ok & ~ls_req;
`endif
      grant_ls = ls_req & ~grant_if;
   end

   // Byte-count decode of ls_len and next-byte address / store data
   always_comb begin
      case (ls_len)
         3'd1:    ls_n = 3'd1;
         3'd2:    ls_n = 3'd2;
         default: ls_n = 3'd4;
      endcase
      idx_next  = idx + 3'd1;
      addr_next = addr + {29'd0, idx_next};
      case (idx_next)
         3'd0:    wr_byte = wdata[7:0];
         3'd1:    wr_byte = wdata[15:8];
         3'd2:    wr_byte = wdata[23:16];
         default: wr_byte = wdata[31:24];
      endcase
   end

   // Final read word: the last byte comes straight from mem_din on the capture edge
   always_comb begin
      case (n)
         3'd1:    load_word = {{24{sgn & mem_din[7]}}, mem_din};
         3'd2:    load_word = {{16{sgn & mem_din[7]}}, mem_din, rbuf[7:0]};
         default: load_word = {mem_din, rbuf};
      endcase
   end

`ifdef STARVE_GUARD_EN
   // Count consecutive LS grants made while IF was waiting; any IF grant clears it
   always_ff @(posedge clk) begin
      if (rst) begin
         starve <= '0;
      end else if (state == IDLE) begin
         if (grant_if) begin
            starve <= '0;
         end else if (grant_ls) begin
            if (!if_req)
               starve <= '0;
            else if (starve != 3'd4)
               starve <= starve + 3'd1;
         end
      end
   end
`endif

   // Transaction FSM with registered RAM-side and done outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         addr     <= '0;
         wdata    <= '0;
         n        <= '0;
         sgn      <= 1'b0;
         owner_ls <= 1'b0;
         idx      <= '0;
         rbuf     <= '0;
         if_done  <= 1'b0;
         if_data  <= '0;
         ls_done  <= 1'b0;
         ls_rdata <= '0;
         mem_dout <= '0;
         mem_a    <= '0;
         mem_wr   <= 1'b0;
      end else begin
         if_done <= 1'b0;
         ls_done <= 1'b0;
         case (state)
            IDLE: begin
               idx  <= '0;
               rbuf <= '0;
               if (grant_ls) begin
                  addr     <= ls_addr;
                  wdata    <= ls_wdata;
                  n        <= ls_n;
                  sgn      <= ls_signed;
                  owner_ls <= 1'b1;
                  mem_a    <= ls_addr;
                  if (ls_we) begin
                     state    <= WRITE;
                     mem_dout <= ls_wdata[7:0];
                     mem_wr   <= 1'b1;
                  end else begin
                     state <= READ;
                  end
               end else if (grant_if) begin
                  addr     <= if_addr;
                  wdata    <= '0;
                  n        <= 3'd4;
                  sgn      <= 1'b0;
                  owner_ls <= 1'b0;
                  mem_a    <= if_addr;
                  state    <= READ;
               end
            end
            READ: begin
               if (!owner_ls && if_abort) begin
                  state <= IDLE;
                  idx   <= '0;
                  mem_a <= '0;
               end else if (idx == n) begin
                  state <= DONE;
                  idx   <= '0;
                  mem_a <= '0;
                  if (owner_ls) begin
                     ls_done  <= 1'b1;
                     ls_rdata <= load_word;
                  end else begin
                     if_done <= 1'b1;
                     if_data <= load_word;
                  end
               end else begin
                  // Data for the address of cycle idx-1 is on mem_din now
                  case (idx)
                     3'd1:    rbuf[7:0]   <= mem_din;
                     3'd2:    rbuf[15:8]  <= mem_din;
                     3'd3:    rbuf[23:16] <= mem_din;
                     default: ;
                  endcase
                  idx   <= idx_next;
                  mem_a <= (idx_next == n) ? '0 : addr_next;
               end
            end
            WRITE: begin
               if (!io_buffer_full) begin
                  if (idx == n - 3'd1) begin
                     state    <= DONE;
                     idx      <= '0;
                     mem_a    <= '0;
                     mem_dout <= '0;
                     mem_wr   <= 1'b0;
                     ls_done  <= 1'b1;
                     ls_rdata <= '0;
                  end else begin
                     idx      <= idx_next;
                     mem_a    <= addr_next;
                     mem_dout <= wr_byte;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: byte-addressed RAM model feeding mem_din,
// directed scenarios followed by randomized fetch/load/store traffic.
module tb_ram_port_arbiter;

   logic        clk;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_abort;
   logic        if_done;
   logic [31:0] if_data;
   logic        ls_req;
   logic        ls_we;
   logic [31:0] ls_addr;
   logic [31:0] ls_wdata;
   logic [2:0]  ls_len;
   logic        ls_signed;
   logic        ls_done;
   logic [31:0] ls_rdata;
   logic [7:0]  mem_din;
   logic        io_buffer_full;
   logic [7:0]  mem_dout;
   logic [31:0] mem_a;
   logic        mem_wr;
   logic        busy;

   int errors = 0;
   int checks = 0;
   int n_if   = 0;
   int n_ls   = 0;

   logic [7:0]  model [bit [31:0]];
   logic [39:0] obs_wr [$];
   byte         seq [$];

   ram_port_arbiter dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_abort(if_abort),
      .if_done(if_done), .if_data(if_data),
      .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
      .ls_len(ls_len), .ls_signed(ls_signed), .ls_done(ls_done), .ls_rdata(ls_rdata),
      .mem_din(mem_din), .io_buffer_full(io_buffer_full),
      .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr), .busy(busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [7:0] mbyte(input logic [31:0] a);
      if (model.exists(a)) return model[a];
      return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h3C;
   endfunction

   function automatic int len_bytes(input logic [2:0] len);
      return (len == 3'd1) ? 1 : (len == 3'd2) ? 2 : 4;
   endfunction

   // Little-endian assembly of n bytes then optional sign extension
   function automatic logic [31:0] exp_load(input logic [31:0] a, input int n, input bit sgn);
      logic [31:0] v;
      v = '0;
      for (int i = 0; i < n; i++)
         v = v | (32'(mbyte(a + 32'(i))) << (8 * i));
      if (sgn && n < 4 && v[8*n-1])
         v = v | ~((32'd1 << (8 * n)) - 32'd1);
      return v;
   endfunction

   // RAM read latency of one cycle, done-pulse counters and accepted writes
   always @(posedge clk) begin
      mem_din <= mbyte(mem_a);
      if (if_done) begin
         n_if <= n_if + 1;
         seq.push_back(8'h46);
      end
      if (ls_done) begin
         n_ls <= n_ls + 1;
         seq.push_back(8'h4C);
      end
      if (mem_wr && !io_buffer_full)
         obs_wr.push_back({mem_a, mem_dout});
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic run_ls(input bit we, input logic [31:0] a, input logic [31:0] wd,
                         input logic [2:0] len, input bit sgn, input bit stall,
                         input string tag, output logic [31:0] got);
      int          n;
      int          base;
      bit          ok;
      logic [31:0] exp;
      n    = len_bytes(len);
      exp  = we ? 32'd0 : exp_load(a, n, sgn);
      got  = 'x;
      obs_wr.delete();
      ls_req = 1'b1; ls_we = we; ls_addr = a; ls_wdata = wd; ls_len = len; ls_signed = sgn;
      ok = 1'b0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (ls_done === 1'b1) begin
            ok = 1'b1;
            break;
         end
         if (stall) io_buffer_full = ($urandom_range(0, 3) == 0);
      end
      check({tag, " done seen"}, 32'(ok), 32'd1);
      ls_req = 1'b0;
      io_buffer_full = 1'b0;
      if (ok) begin
         got  = ls_rdata;
         base = n_ls;
         check({tag, " rdata"}, ls_rdata, exp);
         @(negedge clk);
         check({tag, " done single"}, 32'(ls_done), 32'd0);
         check({tag, " done count"}, 32'(n_ls - base), 32'd1);
      end
      if (we) begin
         check({tag, " write count"}, 32'(obs_wr.size()), 32'(n));
         for (int i = 0; i < n && i < obs_wr.size(); i++) begin
            check({tag, " write addr"}, obs_wr[i][39:8], a + 32'(i));
            check({tag, " write byte"}, 32'(obs_wr[i][7:0]), 32'(wd[8*i +: 8]));
         end
         for (int i = 0; i < n; i++) model[a + 32'(i)] = wd[8*i +: 8];
      end
   endtask

   task automatic run_if(input logic [31:0] a, input string tag);
      bit ok;
      int base;
      if_req = 1'b1; if_addr = a;
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (if_done === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      check({tag, " done seen"}, 32'(ok), 32'd1);
      if_req = 1'b0;
      if (ok) begin
         base = n_if;
         check({tag, " data"}, if_data, exp_load(a, 4, 1'b0));
         @(negedge clk);
         check({tag, " done count"}, 32'(n_if - base), 32'd1);
      end
   endtask

   initial begin
      logic [31:0] got;
      logic [31:0] a;
      logic [31:0] wd;
      logic [2:0]  len;
      string       exp_seq;
      int          base_if;
      int          base_ls;
      int          nl;
      bit          ok;

      rst = 1'b1; if_req = 1'b0; if_addr = '0; if_abort = 1'b0;
      ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0; ls_len = '0;
      ls_signed = 1'b0; io_buffer_full = 1'b0;
      model[32'h100] = 8'h13; model[32'h101] = 8'h00;
      model[32'h102] = 8'h00; model[32'h103] = 8'h00;
      model[32'h20]  = 8'h80;
      repeat (3) @(negedge clk);

      // Reset state
      check("rst busy", 32'(busy), 32'd0);
      check("rst mem_a", mem_a, 32'd0);
      check("rst mem_wr", 32'(mem_wr), 32'd0);
      check("rst mem_dout", 32'(mem_dout), 32'd0);
      check("rst if_done", 32'(if_done), 32'd0);
      check("rst ls_done", 32'(ls_done), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Fetch at 0x100: address sequence and done timing
      if_req = 1'b1; if_addr = 32'h100;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("fetch mem_a", mem_a, 32'h100 + 32'(k));
         check("fetch mem_wr", 32'(mem_wr), 32'd0);
         check("fetch busy", 32'(busy), 32'd1);
      end
      @(negedge clk);
      check("fetch idx4 mem_a", mem_a, 32'd0);
      check("fetch idx4 no done", 32'(if_done), 32'd0);
      @(negedge clk);
      check("fetch done", 32'(if_done), 32'd1);
      check("fetch data", if_data, 32'h0000_0013);
      check("fetch done mem_a", mem_a, 32'd0);
      if_req = 1'b0;
      @(negedge clk);
      check("fetch done pulse", 32'(if_done), 32'd0);
      check("fetch hold data", if_data, 32'h0000_0013);

      // Byte loads with sign and zero extension
      run_ls(1'b0, 32'h20, 32'd0, 3'd1, 1'b1, 1'b0, "load s8", got);
      check("load s8 const", got, 32'hFFFF_FF80);
      run_ls(1'b0, 32'h20, 32'd0, 3'd1, 1'b0, 1'b0, "load u8", got);
      check("load u8 const", got, 32'h0000_0080);

      // Store halfword with backpressure on byte 1
      obs_wr.delete();
      ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h30000; ls_wdata = 32'h1234_ABCD;
      ls_len = 3'd2; ls_signed = 1'b0;
      @(negedge clk);
      check("st b0 mem_a", mem_a, 32'h30000);
      check("st b0 dout", 32'(mem_dout), 32'hCD);
      check("st b0 wr", 32'(mem_wr), 32'd1);
      @(negedge clk);
      check("st b1 mem_a", mem_a, 32'h30001);
      check("st b1 dout", 32'(mem_dout), 32'hAB);
      io_buffer_full = 1'b1;
      for (int s = 0; s < 3; s++) begin
         @(negedge clk);
         check("st hold mem_a", mem_a, 32'h30001);
         check("st hold dout", 32'(mem_dout), 32'hAB);
         check("st hold wr", 32'(mem_wr), 32'd1);
         check("st hold no done", 32'(ls_done), 32'd0);
      end
      io_buffer_full = 1'b0;
      base_ls = n_ls;
      @(negedge clk);
      check("st done", 32'(ls_done), 32'd1);
      check("st rdata", ls_rdata, 32'd0);
      check("st done mem_wr", 32'(mem_wr), 32'd0);
      ls_req = 1'b0;
      @(negedge clk);
      check("st done count", 32'(n_ls - base_ls), 32'd1);
      check("st writes", 32'(obs_wr.size()), 32'd2);
      if (obs_wr.size() == 2) begin
         check("st w0", 32'(obs_wr[0]), {24'h03_0000, 8'hCD});
         check("st w1", 32'(obs_wr[1]), {24'h03_0001, 8'hAB});
      end
      model[32'h30000] = 8'hCD; model[32'h30001] = 8'hAB;

      // Simultaneous requests: load first, then fetch
      base_if = n_if;
      if_req = 1'b1; if_addr = 32'h100;
      run_ls(1'b0, 32'h30000, 32'd0, 3'd2, 1'b1, 1'b0, "prio load", got);
      check("prio no fetch yet", 32'(n_if - base_if), 32'd0);
      check("prio load value", got, 32'hFFFF_ABCD);
      run_if(32'h100, "prio fetch");
      check("prio fetch once", 32'(n_if - base_if), 32'd1);

      // Abort at fetch index 2 with a load waiting
      base_if = n_if;
      if_req = 1'b1; if_addr = 32'h200;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      check("abort idx2 mem_a", mem_a, 32'h202);
      if_abort = 1'b1;
      ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h20; ls_len = 3'd1; ls_signed = 1'b0;
      @(negedge clk);
      check("abort busy", 32'(busy), 32'd0);
      check("abort mem_a", mem_a, 32'd0);
      if_abort = 1'b0; if_req = 1'b0;
      run_ls(1'b0, 32'h20, 32'd0, 3'd1, 1'b0, 1'b0, "abort load", got);
      check("abort no if_done", 32'(n_if - base_if), 32'd0);

      // Reset in the middle of a store
      base_ls = n_ls;
      ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h500; ls_wdata = 32'hDEAD_BEEF; ls_len = 3'd4;
      @(negedge clk);
      @(negedge clk);
      check("mid-rst idx1 wr", 32'(mem_wr), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      check("mid-rst mem_wr", 32'(mem_wr), 32'd0);
      check("mid-rst busy", 32'(busy), 32'd0);
      check("mid-rst mem_a", mem_a, 32'd0);
      check("mid-rst ls_rdata", ls_rdata, 32'd0);
      check("mid-rst if_data", if_data, 32'd0);
      rst = 1'b0; ls_req = 1'b0;
      repeat (4) @(negedge clk);
      check("mid-rst no ls_done", 32'(n_ls - base_ls), 32'd0);

      // Held fetch against back-to-back loads
      seq.delete();
`ifdef STARVE_GUARD_EN
      exp_seq = "LLLLFLF";
`else
      exp_seq = "LLLLLF";
`endif
      if_req = 1'b1; if_addr = 32'h100;
      ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h20; ls_len = 3'd1; ls_signed = 1'b0;
      for (int i = 0; i < 300 && seq.size() < exp_seq.len(); i++) begin
         @(negedge clk);
         nl = 0;
         foreach (seq[j]) if (seq[j] == 8'h4C) nl++;
         if (nl >= 5) ls_req = 1'b0;
      end
      if_req = 1'b0; ls_req = 1'b0;
      check("starve seq len", 32'(seq.size()), 32'(exp_seq.len()));
      for (int i = 0; i < exp_seq.len() && i < seq.size(); i++)
         check("starve seq", 32'(seq[i]), 32'(exp_seq[i]));
      repeat (3) @(negedge clk);

      // Randomized traffic including addresses that wrap past 0xFFFFFFFF
      for (int it = 0; it < 40; it++) begin
         if ($urandom_range(0, 3) == 0)
            a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
         else
            a = 32'h400 + 32'($urandom_range(0, 31));
         wd  = $urandom;
         len = 3'($urandom_range(0, 7));
         case ($urandom_range(0, 2))
            0:       run_if(a, "rnd fetch");
            1:       run_ls(1'b0, a, 32'd0, len, 1'($urandom_range(0, 1)), 1'b0, "rnd load", got);
            default: run_ls(1'b1, a, wd, len, 1'b0, 1'b1, "rnd store", got);
         endcase
      end

      // Bus returns to quiet after traffic
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (!busy) begin
            ok = 1'b1;
            break;
         end
      end
      check("final idle", 32'(ok), 32'd1);
      check("final mem_wr", 32'(mem_wr), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
